// File: rtl/tbird_fsm.sv
// Thunderbird tail-light sequencer: three lamps per side, outward turn sweep, hazard flash.
// Define TBIRD_PRESCALE_EN to step the FSM once every TICK_DIV clocks instead of every clock.
module tbird_fsm #(
  parameter int TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       haz,
  output logic [5:0] light
);

  // Each state code is its own lamp pattern, so light is a straight copy of the
  // state flops and cannot glitch; the other 56 codes are unused.
  typedef enum logic [5:0] {
    IDLE = 6'b000000,
    L1   = 6'b001000,
    L2   = 6'b011000,
    L3   = 6'b111000,
    R1   = 6'b000100,
    R2   = 6'b000110,
    R3   = 6'b000111,
    LR3  = 6'b111111
  } state_t;

  state_t state, state_nxt;
  logic   step;

`ifdef TBIRD_PRESCALE_EN
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign step = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  // TICK_DIV must be at least 1, so this is always high.
  assign step = (TICK_DIV >= 1);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (step) begin
      unique case (state)
        IDLE: begin
          if (haz || (left && right)) begin
            state_nxt = LR3;
          end else if (left) begin
            state_nxt = L1;
          end else if (right) begin
            state_nxt = R1;
          end else begin
            state_nxt = IDLE;
          end
        end
        L1:      state_nxt = haz ? LR3 : L2;
        L2:      state_nxt = haz ? LR3 : L3;
        R1:      state_nxt = haz ? LR3 : R2;
        R2:      state_nxt = haz ? LR3 : R3;
        L3:      state_nxt = IDLE;
        R3:      state_nxt = IDLE;
        LR3:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign light = state;

endmodule

// File: tb/tb_tbird_fsm.sv
// Randomized self-checking bench for tbird_fsm against a phase/side lamp model.
module tb_tbird_fsm;

  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       left;
  logic       right;
  logic       haz;
  logic [5:0] light;

  int tests = 0;
  int fails = 0;

  // Model: phase 0 = dark, 1..3 = lamps lit on the active side, flash = all six on.
  int phase;
  int side;
  bit flash;
  int divc;

  always #5 clk = ~clk;

  tbird_fsm #(.TICK_DIV(TICK_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .left  (left),
    .right (right),
    .haz   (haz),
    .light (light)
  );

  function automatic logic [5:0] modelLight();
    logic [2:0] t;
    if (flash) return 6'b111111;
    t = 3'((1 << phase) - 1);
    if (phase == 0)  return 6'b000000;
    if (side == 0)   return {t, 3'b000};
    return {3'b000, t[0], t[1], t[2]};
  endfunction

  task automatic modelStep(input bit l, input bit r, input bit h, input bit rst);
    bit tick;
    if (!rst) begin
      phase = 0;
      flash = 0;
      divc  = 0;
      return;
    end
`ifdef TBIRD_PRESCALE_EN
    tick = (divc == TICK_DIV - 1);
    divc = tick ? 0 : divc + 1;
`else
    tick = 1'b1;
`endif
    if (!tick) return;
    if (flash || phase == 3) begin
      flash = 0;
      phase = 0;
    end else if (phase == 0) begin
      if (h || (l && r)) begin
        flash = 1;
      end else if (l) begin
        side  = 0;
        phase = 1;
      end else if (r) begin
        side  = 1;
        phase = 1;
      end
    end else if (h) begin
      flash = 1;
      phase = 0;
    end else begin
      phase = phase + 1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [5:0] got, input logic [5:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: light=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  // Check the result of the previous edge, then drive inputs for the next one.
  task automatic applyStimulus(input string tag, input bit l, input bit r, input bit h, input bit rst);
    @(negedge clk);
    checkOutput(tag, light, modelLight());
    left  = l;
    right = r;
    haz   = h;
    reset = rst;
    modelStep(l, r, h, rst);
  endtask

  logic [5:0] lefttbl [7];

  initial begin
    lefttbl = '{6'b001000, 6'b011000, 6'b111000, 6'b000000,
                6'b001000, 6'b011000, 6'b111000};
    side  = 0;
    left  = 1'b0;
    right = 1'b0;
    haz   = 1'b0;
    reset = 1'b0;
    modelStep(0, 0, 0, 0);

    for (int i = 0; i < 3; i++) applyStimulus("reset_idle", 0, 0, 0, 1);

    for (int i = 0; i < 7; i++) begin
      applyStimulus("left_hold", 1, 0, 0, 1);
`ifndef TBIRD_PRESCALE_EN
      @(posedge clk);
      #1;
      checkOutput("left_table", light, lefttbl[i]);
`endif
    end
    applyStimulus("left_drop", 0, 0, 0, 0);

    for (int i = 0; i < 8 * TICK_DIV; i++) applyStimulus("right_hold", 0, 1, 0, 1);
    applyStimulus("right_rst", 0, 1, 0, 0);

    // Right sweep to R2, then hazard takes over and flashes.
    for (int i = 0; i < 2 * TICK_DIV; i++) applyStimulus("right_to_r2", 0, 1, 0, 1);
    for (int i = 0; i < 5 * TICK_DIV; i++) applyStimulus("haz_flash", 0, 1, 1, 1);
    for (int i = 0; i < 5 * TICK_DIV; i++) applyStimulus("haz_release", 0, 1, 0, 1);

    applyStimulus("both_rst", 0, 0, 0, 0);
    for (int i = 0; i < 3 * TICK_DIV; i++) applyStimulus("both_turns", 1, 1, 0, 1);

    // Opposite turn during a left sweep is ignored until IDLE.
    applyStimulus("opp_rst", 0, 0, 0, 0);
    applyStimulus("opp_left", 1, 0, 0, 1);
    for (int i = 0; i < 4 * TICK_DIV; i++) applyStimulus("opp_right", 0, 1, 0, 1);

    applyStimulus("mid_rst_pre", 0, 0, 0, 0);
    for (int i = 0; i < 2 * TICK_DIV; i++) applyStimulus("mid_left", 1, 0, 0, 1);
    applyStimulus("mid_reset", 1, 0, 1, 0);
    applyStimulus("after_reset", 0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus("random",
                    $urandom_range(0, 9) < 4,
                    $urandom_range(0, 9) < 4,
                    $urandom_range(0, 14) == 0,
                    $urandom_range(0, 59) != 0);
    end
    applyStimulus("final", 0, 0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
